// File: rtl/blkarb.sv
// Block arbiter: round-robin polls NSRC sources for a control word, then streams the whole block from the locked source.
// Optional framing-error counter enabled by defining BLKARB_ERRCNT_EN.
module blkarb #(
  parameter int NSRC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [NSRC-1:0]      give,
  input  logic [NSRC-1:0]      have,
  input  logic [16*NSRC-1:0]   din,
  input  logic [NSRC-1:0]      srcen,
  input  logic                 ofull,
  output logic [15:0]          dout,
  output logic                 dvld,
  output logic [15:0]          errcnt
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic {IDLE, BODY} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;
  logic [8:0]    cnt;
  logic [15:0]   word;
  logic          xfer;

  function automatic logic [PW-1:0] next_src(input logic [PW-1:0] s);
    return (s == PW'(NSRC - 1)) ? '0 : s + PW'(1);
  endfunction

  // NOTE: every variable driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    idx  = (state == BODY) ? sel : ptr;
    word = din[{idx, 4'b0000} +: 16];
    give = '0;
    // Gated with rst_n so the request drops the moment reset is asserted.
    if (rst_n) begin
      if (state == BODY) give[sel] = ~ofull;
      else               give[ptr] = ~ofull & srcen[ptr];
    end
  end

  assign xfer = |(give & have);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
      dout  <= '0;
      dvld  <= 1'b0;
    end else begin
      dvld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && word[15]) begin
            dout <= word;
            dvld <= 1'b1;
            sel  <= ptr;
            cnt  <= word[8:0];
            if (word[8:0] != 9'd0) state <= BODY;
            else                   ptr   <= next_src(ptr);
          end else begin
            // Empty poll, masked source, or a stray data word (dropped).
            ptr <= next_src(ptr);
          end
        end
        BODY: begin
          if (xfer) begin
            dout <= word;
            dvld <= 1'b1;
            cnt  <= cnt - 9'd1;
            if (cnt == 9'd1) begin
              state <= IDLE;
              ptr   <= next_src(sel);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLKARB_ERRCNT_EN
  logic frame_err;

  // A data word where a CW is expected, or a CW-looking word inside a body.
  assign frame_err = xfer && ((state == IDLE) ? ~word[15] : word[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               errcnt <= '0;
    else if (frame_err && errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
  end
`else
  assign errcnt = '0;
`endif

endmodule

// File: doc/blkarb.md
BLKARB -- requirements
Module: blkarb

Interface
REQ-001 Parameter NSRC, 4, number of block sources sharing the output link (2..8).
REQ-002 clk  input  1  master clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 give  output  NSRC  per-source read request; at most one bit set per cycle.
REQ-005 have  input  NSRC  per-source word-valid; meaningful only while matching give bit is set.
REQ-006 din  input  16*NSRC  source words; source i on bits 16*i+15..16*i, valid in cycles with give[i]&have[i].
REQ-007 srcen  input  NSRC  source enable mask.
REQ-008 ofull  input  1  downstream almost-full; downstream guarantees at least 2 words of slack after assertion.
REQ-009 dout  output  16  registered output word.
REQ-010 dvld  output  1  dout valid strobe, one word per cycle.
REQ-011 errcnt  output  16  framing error count (see Configuration).

Function
REQ-012 A word SHALL transfer from source i in every cycle where give[i]&have[i]=1; dout=din[i] and dvld=1 SHALL appear on the following cycle (latency 1); dvld=0 otherwise.
REQ-013 Block format: control word (CW) has bit15=1 and length L in bits 8:0; the block is CW plus L following words.
REQ-014 States: IDLE (poll for CW), BODY (stream L words from the locked source).
REQ-015 IDLE: when ofull=0 and srcen[ptr]=1, give[ptr] SHALL be asserted for one cycle; otherwise give=0.
REQ-016 IDLE poll, no transfer, or srcen[ptr]=0: ptr SHALL advance to (ptr+1) mod NSRC next cycle.
REQ-017 IDLE transfer with bit15=1: word forwarded; sel<=ptr; cnt<=L; if L!=0 go BODY, else stay IDLE with ptr<=(ptr+1) mod NSRC.
REQ-018 IDLE transfer with bit15=0: framing error; word SHALL be discarded (dvld=0 next cycle); ptr advances; state stays IDLE.
REQ-019 BODY: give[sel] SHALL equal ~ofull; other give bits SHALL be 0; srcen changes SHALL NOT abort the block.
REQ-020 BODY transfer: word forwarded unconditionally; cnt decrements; bit15=1 in a body word SHALL count as a framing error but is still forwarded.
REQ-021 BODY transfer with cnt=1: go IDLE, ptr<=(sel+1) mod NSRC (round-robin fairness, one block per grant).
REQ-022 BODY with have=0: hold state and cnt indefinitely, no timeout.
REQ-023 ofull asserted: give SHALL drop the same cycle (combinational from ofull); at most the already registered word emerges after it.
REQ-024 cnt SHALL be 9 bits; L=511 SHALL yield 512 forwarded words.
REQ-025 All srcen=0 in IDLE: give stays 0, ptr keeps rotating.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, ptr=0, sel=0, cnt=0, give=0, dvld=0, dout=0, errcnt=0, regardless of a block in progress.
REQ-027 A block interrupted by reset is not resumed; the first post-reset word accepted from any source is treated as a CW candidate.

Configuration
REQ-028 Macro BLKARB_ERRCNT_EN defined: errcnt increments by 1 per framing error (REQ-018, REQ-020), saturates at 16'hFFFF.
REQ-029 BLKARB_ERRCNT_EN undefined: errcnt tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-030 Src0 holds CW 0x8003+3 words, others empty -> dout 0x8003,w1,w2,w3 on consecutive cycles, then poll continues at src1.
REQ-031 Src0 and src2 each hold one L=2 block, ptr=0 -> src0 block fully forwarded, then src2 block; no interleaving.
REQ-032 Src1 presents 0x1234 in IDLE -> word dropped, errcnt=1 (0 with macro off), next poll src2.
REQ-033 ofull raised mid-block of L=8 after 3 words -> give drops same cycle, at most 1 further dvld, resumes on ofull=0, total 9 words.
REQ-034 CW 0x8000 from src3 -> single word forwarded, state stays IDLE, next poll src0.
REQ-035 rst_n low for 1 cycle mid-BODY -> give=0, dvld=0, errcnt=0 immediately; restart polls src0.
